// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response/ALU bus bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;

  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;

  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_y,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    output alu_op, alu_a, alu_b,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_y,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  alu_op, alu_a, alu_b,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_busy;

  logic             w_idle;
  logic             w_grant1;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_accept;

  // Grant selection: a lone requester always wins, a tie goes to the priority holder
  always_comb begin
    w_idle   = (r_state == ST_IDLE);
    w_grant1 = bus.req1_valid & (~bus.req0_valid | r_prio);
    w_rdy0   = w_idle & bus.req0_valid & ~w_grant1;
    w_rdy1   = w_idle & bus.req1_valid &  w_grant1;
    w_accept = w_rdy0 | w_rdy1;
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_data   = r_data;
  assign bus.alu_op     = r_op;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.busy       = r_busy;

  // Transaction FSM; operand regs double as the ALU drive and are cleared on return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_data      <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_grant1 ? bus.req1_op : bus.req0_op;
            r_a     <= w_grant1 ? bus.req1_a  : bus.req0_a;
            r_b     <= w_grant1 ? bus.req1_b  : bus.req0_b;
            r_id    <= w_grant1;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_data      <= bus.alu_y;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_prio      <= ~r_id;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
